// File: rtl/comparator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_pkg
//  Description : Shared opcode encodings, FSM states and result helpers for
//                the iterative sequential comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
package comparator_pkg;

  // Branch-style opcode encodings (010/011 are illegal)
  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b100;
  localparam logic [2:0] CMP_GE  = 3'b101;
  localparam logic [2:0] CMP_LTU = 3'b110;
  localparam logic [2:0] CMP_GEU = 3'b111;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Only the LTU/GEU pair compares unsigned; everything else is biased
  function automatic logic op_is_signed(input logic [2:0] op);
    return op[2:1] != 2'b11;
  endfunction

  // Map final flags onto the requested op; illegal ops yield 0
  function automatic logic op_result(input logic [2:0] op,
                                     input logic       eq,
                                     input logic       lt);
    logic res;
    res = 1'b0;
    case (op)
      CMP_EQ:            res = eq;
      CMP_NE:            res = ~eq;
      CMP_LT,  CMP_LTU:  res = lt;
      CMP_GE,  CMP_GEU:  res = ~lt;
      default:           res = 1'b0;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_comparator_slice_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : slice_cmp
//  Description : Combinational unsigned compare of one operand slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module slice_cmp #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a_slc,
  input  logic [SLICE-1:0] b_slc,
  output logic             eq,
  output logic             lt
);

  assign eq = (a_slc == b_slc);
  assign lt = (a_slc <  b_slc);

endmodule
`default_nettype wire

// File: rtl/seq_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : seq_comparator
//  Description : Iterative integer comparator, one SLICE-bit slice per cycle,
//                MSB slice first, early exit on the first differing slice.
//                Optional min/max output enabled by COMPARATOR_MINMAX_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             FLUSH,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             R,
  output logic             EQ_F,
  output logic             LT_F
`ifdef COMPARATOR_MINMAX_EN
  ,
  input  logic             MM_MAX,
  output logic [WIDTH-1:0] MM_OUT
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NSLICE - 1);

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("seq_comparator: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_q;       // biased operand A
  logic [WIDTH-1:0] b_q;       // biased operand B
  logic [2:0]       op_q;
  logic             sgn_q;     // capture-time signedness, also undoes bias
  logic [IDX_W-1:0] idx;

  // Split the held operands into slices so one comparator can be muxed
  logic [SLICE-1:0] a_sl [NSLICE];
  logic [SLICE-1:0] b_sl [NSLICE];

  generate
    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
      assign a_sl[g] = a_q[g*SLICE +: SLICE];
      assign b_sl[g] = b_q[g*SLICE +: SLICE];
    end
  endgenerate

  logic slc_eq;
  logic slc_lt;

  slice_cmp #(.SLICE(SLICE)) u_slice_cmp (
    .a_slc (a_sl[idx]),
    .b_slc (b_sl[idx]),
    .eq    (slc_eq),
    .lt    (slc_lt)
  );

  // Compare ends on a differing slice or after the last (LSB) slice
  logic finish;
  logic eq_n;
  logic lt_n;
  assign finish = ~slc_eq | (idx == '0);
  assign eq_n   = slc_eq;
  assign lt_n   = ~slc_eq & slc_lt;

  assign in_ready = (state == IDLE);

`ifdef COMPARATOR_MINMAX_EN
  logic             mm_max_q;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] b_orig;
  assign a_orig = {a_q[WIDTH-1] ^ sgn_q, a_q[WIDTH-2:0]};
  assign b_orig = {b_q[WIDTH-1] ^ sgn_q, b_q[WIDTH-2:0]};

  // Min/max result captured alongside the flags and held with out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_max_q <= 1'b0;
      MM_OUT   <= '0;
    end else if (!FLUSH) begin
      if (state == IDLE && in_valid)
        mm_max_q <= MM_MAX;
      else if (state == BUSY && finish)
        MM_OUT <= (mm_max_q ^ lt_n) ? a_orig : b_orig;
    end
  end
`endif

  // Main control: capture, slice walk, result hold and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      sgn_q     <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      R         <= 1'b0;
      EQ_F      <= 1'b0;
      LT_F      <= 1'b0;
    end else if (FLUSH) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Inverting both MSBs turns a signed compare into an unsigned one
            a_q   <= {A[WIDTH-1] ^ op_is_signed(OP), A[WIDTH-2:0]};
            b_q   <= {B[WIDTH-1] ^ op_is_signed(OP), B[WIDTH-2:0]};
            op_q  <= OP;
            sgn_q <= op_is_signed(OP);
            idx   <= IDX_MSB;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            EQ_F      <= eq_n;
            LT_F      <= lt_n;
            R         <= op_result(op_q, eq_n, lt_n);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_comparator
//  Description : Self-checking bench for seq_comparator (WIDTH=64, SLICE=16).
//                Min/max checks follow COMPARATOR_MINMAX_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_comparator;

  localparam int WIDTH  = 64;
  localparam int SLICE  = 16;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       OP;
  logic             FLUSH;
  logic             out_valid;
  logic             out_ready;
  logic             R;
  logic             EQ_F;
  logic             LT_F;
  logic             MM_MAX;
  logic [WIDTH-1:0] MM_OUT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_comparator #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .FLUSH     (FLUSH),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .EQ_F      (EQ_F),
    .LT_F      (LT_F)
`ifdef COMPARATOR_MINMAX_EN
    ,
    .MM_MAX    (MM_MAX),
    .MM_OUT    (MM_OUT)
`endif
  );

`ifndef COMPARATOR_MINMAX_EN
  assign MM_OUT = '0;
`endif

  // ---------------- reference model ----------------
  function automatic logic m_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [2:0] op);
    if (op == 3'b110 || op == 3'b111) return a < b;
    return $signed(a) < $signed(b);
  endfunction

  function automatic logic m_r(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [2:0] op);
    case (op)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100, 3'b110: return m_lt(a, b, op);
      3'b101, 3'b111: return !m_lt(a, b, op);
      default: return 1'b0;
    endcase
  endfunction

  // Cycles = slices walked from the top down to the first differing one
  function automatic int m_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x;
    x = a ^ b;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (x[i]) return NSLICE - i / SLICE;
    return NSLICE;
  endfunction

  function automatic logic [WIDTH-1:0] m_mm(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic [2:0] op, input logic mx);
    if (a == b) return a;
    if (mx) return m_lt(a, b, op) ? b : a;
    return m_lt(a, b, op) ? a : b;
  endfunction

  // ---------------- drivers ----------------
  // Issue one request and wait (bounded) for out_valid; lat = edges after accept
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] op, input logic mx,
                        output int lat, output logic ir_busy);
    in_valid = 1'b1; A = a; B = b; OP = op; MM_MAX = mx;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; OP = 3'($urandom); MM_MAX = 1'($urandom);
    ir_busy = in_ready;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake(output logic ov, output logic ir);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ov = out_valid;
    ir = in_ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
    n_checks++; if ({R, EQ_F, LT_F} !== 3'b000) begin n_fail++; $display("FAIL reset flags got %b exp 000", {R, EQ_F, LT_F}); end
`ifdef COMPARATOR_MINMAX_EN
    n_checks++; if (MM_OUT !== '0) begin n_fail++; $display("FAIL reset mm_out got %h exp 0", MM_OUT); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] av [6];
    logic [WIDTH-1:0] bv [6];
    logic [2:0]       ov [6];
    int lat; logic irb, ovh, irh;
    av[0] = 64'd5;                bv[0] = 64'd7;   ov[0] = 3'b110;
    av[1] = 64'h8000_0000_0000_0000; bv[1] = 64'd1; ov[1] = 3'b100;
    av[2] = 64'h8000_0000_0000_0000; bv[2] = 64'd1; ov[2] = 3'b110;
    av[3] = '1;                   bv[3] = '1;      ov[3] = 3'b000;
    av[4] = '1;                   bv[4] = '1;      ov[4] = 3'b101;
    av[5] = '1;                   bv[5] = '1;      ov[5] = 3'b010;
    for (int k = 0; k < 6; k++) begin
      run_op(av[k], bv[k], ov[k], 1'b1, lat, irb);
      n_checks++; if (irb !== 1'b0) begin n_fail++; $display("FAIL dir%0d in_ready_busy got %b exp 0", k, irb); end
      n_checks++; if (lat != m_lat(av[k], bv[k])) begin n_fail++; $display("FAIL dir%0d latency got %0d exp %0d", k, lat, m_lat(av[k], bv[k])); end
      n_checks++; if (R !== m_r(av[k], bv[k], ov[k])) begin n_fail++; $display("FAIL dir%0d R got %b exp %b", k, R, m_r(av[k], bv[k], ov[k])); end
      n_checks++; if (EQ_F !== (av[k] == bv[k])) begin n_fail++; $display("FAIL dir%0d EQ_F got %b exp %b", k, EQ_F, av[k] == bv[k]); end
      if (ov[k] != 3'b010) begin
        n_checks++; if (LT_F !== m_lt(av[k], bv[k], ov[k])) begin n_fail++; $display("FAIL dir%0d LT_F got %b exp %b", k, LT_F, m_lt(av[k], bv[k], ov[k])); end
      end
      handshake(ovh, irh);
      n_checks++; if ({ovh, irh} !== 2'b01) begin n_fail++; $display("FAIL dir%0d release ov/ir got %b exp 01", k, {ovh, irh}); end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic irb, ovh, irh;
    run_op(64'd5, 64'd7, 3'b110, 1'b0, lat, irb);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, R, EQ_F, LT_F} !== 5'b10101) begin
        n_fail++; $display("FAIL hold%0d ov/ir/R/EQ/LT got %b exp 10101", k, {out_valid, in_ready, R, EQ_F, LT_F});
      end
`ifdef COMPARATOR_MINMAX_EN
      n_checks++; if (MM_OUT !== 64'd5) begin n_fail++; $display("FAIL hold%0d mm_out got %h exp 5", k, MM_OUT); end
`endif
    end
    handshake(ovh, irh);
    n_checks++; if ({ovh, irh} !== 2'b01) begin n_fail++; $display("FAIL hold release ov/ir got %b exp 01", {ovh, irh}); end
  endtask

  task automatic test_reset_mid();
    int seen; int lat; logic irb, ovh, irh;
    // Reset during BUSY
    in_valid = 1'b1; A = '0; B = '0; OP = 3'b000;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_busy ov/ir got %b exp 01", {out_valid, in_ready}); end
    @(posedge clk); #1; rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_checks++; if (seen != 0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_busy after ov_count=%0d ir=%b exp 0/1", seen, in_ready); end
    // Reset while DONE holds a result
    run_op(64'd3, 64'd3, 3'b000, 1'b0, lat, irb);
    rst_n = 1'b0; #1;
    n_checks++; if ({out_valid, R, EQ_F} !== 3'b000) begin n_fail++; $display("FAIL rst_done ov/R/EQ got %b exp 000", {out_valid, R, EQ_F}); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(64'd9, 64'd2, 3'b101, 1'b0, lat, irb);
    n_checks++; if ({out_valid, R} !== 2'b11) begin n_fail++; $display("FAIL rst_recover ov/R got %b exp 11", {out_valid, R}); end
    handshake(ovh, irh);
  endtask

  task automatic test_flush();
    int seen; int lat; logic irb;
    // FLUSH while BUSY
    in_valid = 1'b1; A = '0; B = '0; OP = 3'b000;
    @(posedge clk); #1; in_valid = 1'b0;
    FLUSH = 1'b1;
    @(posedge clk); #1; FLUSH = 1'b0;
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_busy ov/ir got %b exp 01", {out_valid, in_ready}); end
    seen = 0;
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_busy late out_valid count got %0d exp 0", seen); end
    // FLUSH beats out_ready in DONE
    run_op(64'd1, 64'd2, 3'b100, 1'b0, lat, irb);
    FLUSH = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; FLUSH = 1'b0; out_ready = 1'b0;
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_done ov/ir got %b exp 01", {out_valid, in_ready}); end
    // FLUSH beats in_valid in IDLE
    FLUSH = 1'b1; in_valid = 1'b1; A = 64'd1; B = 64'd1; OP = 3'b000;
    @(posedge clk); #1; FLUSH = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (out_valid || !in_ready) seen++; end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_idle accepted request busy_cycles got %0d exp 0", seen); end
  endtask

  // Shared body for swept and random operands
  task automatic check_one(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [2:0] op, input logic mx);
    int lat; logic irb, ovh, irh;
    run_op(a, b, op, mx, lat, irb);
    n_checks++;
    if (R !== m_r(a, b, op) || EQ_F !== (a == b) || LT_F !== m_lt(a, b, op) || lat != m_lat(a, b)) begin
      n_fail++;
      $display("FAIL %s a=%h b=%h op=%b R/EQ/LT/lat got %b%b%b/%0d exp %b%b%b/%0d", tag, a, b, op,
               R, EQ_F, LT_F, lat, m_r(a, b, op), a == b, m_lt(a, b, op), m_lat(a, b));
    end
`ifdef COMPARATOR_MINMAX_EN
    n_checks++;
    if (MM_OUT !== m_mm(a, b, op, mx)) begin
      n_fail++; $display("FAIL %s mm a=%h b=%h op=%b max=%b got %h exp %h", tag, a, b, op, mx, MM_OUT, m_mm(a, b, op, mx));
    end
`endif
    handshake(ovh, irh);
  endtask

  task automatic test_sweep();
    logic [2:0] ops [6];
    logic [WIDTH-1:0] a, b;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100;
    ops[3] = 3'b101; ops[4] = 3'b110; ops[5] = 3'b111;
    for (int i = -128; i < 128; i += 15)
      for (int j = -128; j < 128; j += 15) begin
        a = WIDTH'(signed'(i)); b = WIDTH'(signed'(j));
        check_one("sweep", a, b, ops[(i + j + 256) % 6], 1'($urandom));
      end
    for (int k = 0; k < 6; k++) begin
      check_one("sweep_eq", 64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80, ops[k], 1'b1);
      check_one("sweep_edge", 64'h0000_0000_0000_007F, 64'hFFFF_FFFF_FFFF_FF80, ops[k], 1'($urandom));
    end
  endtask

  task automatic test_random();
    logic [2:0] ops [6];
    logic [WIDTH-1:0] a, b;
    int sl;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100;
    ops[3] = 3'b101; ops[4] = 3'b110; ops[5] = 3'b111;
    for (int k = 0; k < 300; k++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0: b = {$urandom, $urandom};
        1: begin
          sl = $urandom_range(0, NSLICE - 1);
          b = a ^ ((WIDTH'($urandom) & WIDTH'(16'hFFFF)) << (sl * SLICE));
        end
        default: b = a;
      endcase
      check_one("random", a, b, ops[$urandom_range(0, 5)], 1'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; OP = '0;
    FLUSH = 1'b0; out_ready = 1'b0; MM_MAX = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_flush();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
